// File: rtl/prog_down_timer.sv
// Programmable down-counter with one-shot / auto-reload modes, pause hold,
// early-warning decode and a saturating count of terminal events.
module prog_down_timer #(
  parameter int unsigned pCNT_WIDTH  = 7,
  parameter int unsigned pPRE_DIST   = 1,
  parameter int unsigned pWRAP_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [pCNT_WIDTH-1:0]  cfg_reload,
  input  logic                   cfg_oneshot,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  output logic [pCNT_WIDTH-1:0]  count,
  output logic                   last,
  output logic                   pre_last,
  output logic                   done,
  output logic                   busy,
  output logic [pWRAP_WIDTH-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [pCNT_WIDTH-1:0] PRE_VAL = pCNT_WIDTH'(pPRE_DIST);

  state_t                 state;
  logic [pCNT_WIDTH-1:0]  reload_r;
  logic                   oneshot_r;
  logic                   terminal;
  logic [pWRAP_WIDTH-1:0] wrap_next;

  assign terminal = (state == RUN) && !pause && (count == '0);

  always_comb begin
    wrap_next = wrap_cnt;
    if (wrap_cnt != '1) wrap_next = wrap_cnt + pWRAP_WIDTH'(1);
  end

  assign busy     = (state != IDLE);
  assign last     = busy && (count == '0);
  assign pre_last = busy && (count == PRE_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      reload_r  <= '0;
      oneshot_r <= 1'b0;
      wrap_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else if (start) begin
        state     <= RUN;
        count     <= cfg_reload;
        reload_r  <= cfg_reload;
        oneshot_r <= cfg_oneshot;
        // A restart coinciding with a terminal event still counts the event.
        if (state == IDLE)  wrap_cnt <= '0;
        else if (terminal)  wrap_cnt <= wrap_next;
      end else begin
        unique case (state)
          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (count != '0) begin
              count <= count - pCNT_WIDTH'(1);
            end else begin
              wrap_cnt <= wrap_next;
              if (oneshot_r) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                count <= reload_r;
              end
            end
          end
          HOLD: if (!pause) state <= RUN;
          default: ;
        endcase
      end
    end
  end

endmodule
